// File: rtl/tsn_axis_pkg.sv
// Shared TSN AXI-Stream definitions: frame route encoding, default widths and
// the per-frame route decision.
package tsn_axis_pkg;

   typedef enum logic [1:0] {
      ROUTE_CT   = 2'd0,
      ROUTE_IT   = 2'd1,
      ROUTE_DROP = 2'd2
   } route_t;

   localparam int DEF_DATA_WIDTH = 256;
   localparam int DEF_CNT_WIDTH  = 32;

   function automatic route_t route_pick(input logic is_it, input logic it_en);
      route_t r;
      if (!is_it)
         r = ROUTE_CT;
      else if (it_en)
         r = ROUTE_IT;
      else
         r = ROUTE_DROP;
      return r;
   endfunction

endpackage

// File: rtl/axis_frame_counter.sv
// Wrapping frame counter with a single-cycle increment enable.
module axis_frame_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         count <= '0;
      else if (inc)
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/axis_it_demux.sv
// Frame-level AXI-Stream demux: steers whole frames to the IT or CT port (or
// drops IT frames) from the checker verdict, with per-class frame counters.
//
// route_q | meaning
// --------+------------------------------------------------------
// CT      | current frame goes to the CT (critical/PTP) port
// IT      | current frame goes to the IT (best-effort) port
// DROP    | current IT frame is consumed with no output
module axis_it_demux
   import tsn_axis_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int CNT_WIDTH  = DEF_CNT_WIDTH,
   localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  axis_aclk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  is_it_frame,
   input  logic                  it_enable,
   output logic [DATA_WIDTH-1:0] m_it_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_it_axis_tkeep,
   output logic                  m_it_axis_tvalid,
   input  logic                  m_it_axis_tready,
   output logic                  m_it_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_ct_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_ct_axis_tkeep,
   output logic                  m_ct_axis_tvalid,
   input  logic                  m_ct_axis_tready,
   output logic                  m_ct_axis_tlast,
   output logic [CNT_WIDTH-1:0]  cnt_it_frames,
   output logic [CNT_WIDTH-1:0]  cnt_ct_frames,
   output logic [CNT_WIDTH-1:0]  cnt_drop_frames
);

   logic                  reg_v;
   logic [DATA_WIDTH-1:0] reg_data;
   logic [KEEP_WIDTH-1:0] reg_keep;
   logic                  reg_last;
   logic                  reg_first;
   logic                  reg_fresh;
   logic                  sop;
   route_t                route_q;
   route_t                route_live;
   route_t                route;
   logic                  decide;
   logic                  sel_ready;
   logic                  out_fire;
   logic                  in_fire;

   // The verdict is taken only in the first cycle a first beat sits in the
   // register, so a stalled first beat cannot change ports while held.
   always_ff @(posedge axis_aclk or negedge rstn) begin
      if (!rstn) begin
         reg_v     <= 1'b0;
         reg_data  <= '0;
         reg_keep  <= '0;
         reg_last  <= 1'b0;
         reg_first <= 1'b0;
         reg_fresh <= 1'b0;
         sop       <= 1'b1;
         route_q   <= ROUTE_CT;
      end else begin
         if (in_fire) begin
            reg_v     <= 1'b1;
            reg_data  <= s_axis_tdata;
            reg_keep  <= s_axis_tkeep;
            reg_last  <= s_axis_tlast;
            reg_first <= sop;
            reg_fresh <= sop;
            sop       <= s_axis_tlast;
         end else begin
            reg_fresh <= 1'b0;
            if (out_fire)
               reg_v <= 1'b0;
         end
         if (decide)
            route_q <= route_live;
      end
   end

   always_comb begin
      route_live = route_pick(is_it_frame, it_enable);
      decide     = reg_v && reg_first && reg_fresh;
      route      = decide ? route_live : route_q;
      case (route)
         ROUTE_IT:   sel_ready = m_it_axis_tready;
         ROUTE_CT:   sel_ready = m_ct_axis_tready;
         ROUTE_DROP: sel_ready = 1'b1;
         default:    sel_ready = 1'b0;
      endcase
      out_fire      = reg_v && sel_ready;
      s_axis_tready = !reg_v || out_fire;
      in_fire       = s_axis_tvalid && s_axis_tready;
   end

   always_comb begin
      m_it_axis_tvalid = reg_v && (route == ROUTE_IT);
      m_ct_axis_tvalid = reg_v && (route == ROUTE_CT);
      m_it_axis_tdata  = reg_data;
      m_it_axis_tkeep  = reg_keep;
      m_it_axis_tlast  = reg_last;
      m_ct_axis_tdata  = reg_data;
      m_ct_axis_tkeep  = reg_keep;
      m_ct_axis_tlast  = reg_last;
   end

   axis_frame_counter #(.WIDTH(CNT_WIDTH)) u_cnt_it (
      .clk   (axis_aclk),
      .rstn  (rstn),
      .inc   (out_fire && reg_last && (route == ROUTE_IT)),
      .count (cnt_it_frames)
   );

   axis_frame_counter #(.WIDTH(CNT_WIDTH)) u_cnt_ct (
      .clk   (axis_aclk),
      .rstn  (rstn),
      .inc   (out_fire && reg_last && (route == ROUTE_CT)),
      .count (cnt_ct_frames)
   );

   axis_frame_counter #(.WIDTH(CNT_WIDTH)) u_cnt_drop (
      .clk   (axis_aclk),
      .rstn  (rstn),
      .inc   (out_fire && reg_last && (route == ROUTE_DROP)),
      .count (cnt_drop_frames)
   );

endmodule

// File: tb/tb_axis_it_demux.sv
// Directed bench for axis_it_demux: a 32-bit-counter instance plus a 4-bit
// counter instance sharing the same stimulus for the wrap check.
module tb_axis_it_demux;

   localparam int DW = 64;
   localparam int KW = DW / 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          s_tvalid;
   logic          s_tready;
   logic          s_tlast;
   logic          is_it;
   logic          it_en;
   logic [DW-1:0] it_data, ct_data;
   logic [KW-1:0] it_keep, ct_keep;
   logic          it_valid, ct_valid, it_last, ct_last;
   logic          it_ready, ct_ready;
   logic [31:0]   c_it, c_ct, c_drop;

   logic [DW-1:0] w_it_data, w_ct_data;
   logic [KW-1:0] w_it_keep, w_ct_keep;
   logic          w_it_valid, w_ct_valid, w_it_last, w_ct_last, w_s_tready;
   logic [3:0]    w_it, w_ct, w_drop;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   axis_it_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
      .axis_aclk(clk), .rstn(rstn),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .is_it_frame(is_it), .it_enable(it_en),
      .m_it_axis_tdata(it_data), .m_it_axis_tkeep(it_keep), .m_it_axis_tvalid(it_valid),
      .m_it_axis_tready(it_ready), .m_it_axis_tlast(it_last),
      .m_ct_axis_tdata(ct_data), .m_ct_axis_tkeep(ct_keep), .m_ct_axis_tvalid(ct_valid),
      .m_ct_axis_tready(ct_ready), .m_ct_axis_tlast(ct_last),
      .cnt_it_frames(c_it), .cnt_ct_frames(c_ct), .cnt_drop_frames(c_drop)
   );

   axis_it_demux #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
      .axis_aclk(clk), .rstn(rstn),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(w_s_tready), .s_axis_tlast(s_tlast),
      .is_it_frame(is_it), .it_enable(it_en),
      .m_it_axis_tdata(w_it_data), .m_it_axis_tkeep(w_it_keep), .m_it_axis_tvalid(w_it_valid),
      .m_it_axis_tready(it_ready), .m_it_axis_tlast(w_it_last),
      .m_ct_axis_tdata(w_ct_data), .m_ct_axis_tkeep(w_ct_keep), .m_ct_axis_tvalid(w_ct_valid),
      .m_ct_axis_tready(ct_ready), .m_ct_axis_tlast(w_ct_last),
      .cnt_it_frames(w_it), .cnt_ct_frames(w_ct), .cnt_drop_frames(w_drop)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic last);
      s_tdata  = d;
      s_tkeep  = '1;
      s_tvalid = 1'b1;
      s_tlast  = last;
   endtask

   task automatic idle();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   initial begin
      rstn = 1'b0;
      s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      is_it = 1'b0; it_en = 1'b1; it_ready = 1'b1; ct_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk("rst_it_valid", it_valid, 0);
      chk("rst_ct_valid", ct_valid, 0);
      chk("rst_s_tready", s_tready, 1);
      chk("rst_cnt_it", c_it, 0);
      chk("rst_cnt_ct", c_ct, 0);
      chk("rst_cnt_drop", c_drop, 0);

      // two-beat IT frame
      step(); beat(64'h11, 1'b0);
      step(); is_it = 1'b1; beat(64'h12, 1'b1);
      smp();
      chk("it2_b0_valid", it_valid, 1);
      chk("it2_b0_ct_valid", ct_valid, 0);
      chk("it2_b0_data", it_data, 64'h11);
      chk("it2_b0_last", it_last, 0);
      step(); idle();
      smp();
      chk("it2_b1_valid", it_valid, 1);
      chk("it2_b1_ct_valid", ct_valid, 0);
      chk("it2_b1_data", it_data, 64'h12);
      chk("it2_b1_last", it_last, 1);
      step();
      smp();
      chk("it2_idle_valid", it_valid, 0);
      chk("it2_cnt_it", c_it, 1);
      chk("it2_cnt_ct", c_ct, 0);

      // back-to-back single-beat CT, IT, CT
      step(); beat(64'h21, 1'b1);
      step(); is_it = 1'b0; beat(64'h22, 1'b1);
      smp();
      chk("b2b_c1_ct_valid", ct_valid, 1);
      chk("b2b_c1_it_valid", it_valid, 0);
      chk("b2b_c1_data", ct_data, 64'h21);
      step(); is_it = 1'b1; beat(64'h23, 1'b1);
      smp();
      chk("b2b_i1_it_valid", it_valid, 1);
      chk("b2b_i1_ct_valid", ct_valid, 0);
      chk("b2b_i1_data", it_data, 64'h22);
      step(); is_it = 1'b0; idle();
      smp();
      chk("b2b_c2_ct_valid", ct_valid, 1);
      chk("b2b_c2_it_valid", it_valid, 0);
      chk("b2b_c2_data", ct_data, 64'h23);
      step();
      smp();
      chk("b2b_cnt_ct", c_ct, 2);
      chk("b2b_cnt_it", c_it, 2);

      // 4-beat IT frame dropped; it_enable raised mid-frame
      it_en = 1'b0;
      step(); beat(64'h31, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         is_it = 1'b1;
         if (i == 1) it_en = 1'b1;
         if (i < 2) beat(64'h32 + i, 1'b0);
         else if (i == 2) beat(64'h34, 1'b1);
         else idle();
         smp();
         chk("drop_it_valid", it_valid, 0);
         chk("drop_ct_valid", ct_valid, 0);
         chk("drop_s_tready", s_tready, 1);
      end
      step(); is_it = 1'b0;
      smp();
      chk("drop_cnt_drop", c_drop, 1);
      chk("drop_cnt_it", c_it, 2);

      // 3-beat CT frame with CT backpressure for 5 cycles
      step(); ct_ready = 1'b0; beat(64'h41, 1'b0);
      step(); beat(64'h42, 1'b0);
      for (int i = 0; i < 5; i++) begin
         smp();
         chk("bp_ct_valid", ct_valid, 1);
         chk("bp_ct_data", ct_data, 64'h41);
         chk("bp_s_tready", s_tready, 0);
         chk("bp_it_valid", it_valid, 0);
         if (i < 4) step();
      end
      step(); ct_ready = 1'b1;
      smp();
      chk("bp_rel_data", ct_data, 64'h41);
      chk("bp_rel_s_tready", s_tready, 1);
      step(); beat(64'h43, 1'b1);
      smp();
      chk("bp_b1_data", ct_data, 64'h42);
      chk("bp_b1_last", ct_last, 0);
      step(); idle();
      smp();
      chk("bp_b2_data", ct_data, 64'h43);
      chk("bp_b2_last", ct_last, 1);
      step();
      smp();
      chk("bp_idle_ct_valid", ct_valid, 0);
      chk("bp_cnt_ct", c_ct, 3);

      // reset in the middle of a CT frame
      step(); beat(64'h51, 1'b0);
      step(); beat(64'h52, 1'b0);
      smp();
      chk("mr_ct_valid_pre", ct_valid, 1);
      #1;
      rstn = 1'b0;
      idle();
      #1;
      chk("mr_ct_valid", ct_valid, 0);
      chk("mr_it_valid", it_valid, 0);
      chk("mr_s_tready", s_tready, 1);
      chk("mr_cnt_ct", c_ct, 0);
      smp();
      rstn = 1'b1;
      step(); beat(64'h61, 1'b1);
      step(); is_it = 1'b1; idle();
      smp();
      chk("mr_next_it_valid", it_valid, 1);
      chk("mr_next_ct_valid", ct_valid, 0);
      chk("mr_next_data", it_data, 64'h61);
      step(); is_it = 1'b0;
      smp();
      chk("mr_next_cnt_it", c_it, 1);

      // 17 single-beat CT frames: 4-bit counter wraps to 1
      for (int i = 0; i < 17; i++) begin
         step(); beat(64'h70 + i, 1'b1);
      end
      step(); idle();
      step();
      smp();
      chk("wrap_cnt_ct_w4", w_ct, 1);
      chk("wrap_cnt_ct_w32", c_ct, 17);
      chk("wrap_cnt_it_w4", w_it, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
